// File: rtl/alu_seq.sv
// alu_seq: registered, parametrised ALU with iterative multiply/divide.
//
// One operation is accepted per in_valid/in_ready handshake and parked in an
// operand latch. On the following edge the latched op is dispatched:
//   - single-cycle ops write the result registers and pulse ack;
//   - MUL/DIV start a bit-serial engine (IDLE -> BUSY -> DONE -> IDLE).
//
// Ports:
//   clk, rst          clock (rising edge), asynchronous active-high reset
//   in_valid/in_ready request / accept (ready whenever the engine is not BUSY)
//   a, b, s           operands and 4-bit opcode
//   res, res_hi       result; res_hi = MUL high half / DIV remainder, else 0
//   carry, zero, ovf  carry/borrow/shift-out, res==0, signed overflow
//   dz                divide by zero
//   ack               one-cycle pulse when outputs are freshly valid
//
// Build option: define ALU_SAT_EN to make ADD/SUB/INC/DEC saturate to the
// signed max/min on overflow instead of wrapping.
module alu_seq #(
  parameter int WIDTH = 8,
  localparam int SHW = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       s,
  output logic [WIDTH-1:0] res,
  output logic [WIDTH-1:0] res_hi,
  output logic             carry,
  output logic             zero,
  output logic             ovf,
  output logic             dz,
  output logic             ack
);

  localparam logic [3:0] OP_ADD = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR  = 4'h3,
                         OP_XOR = 4'h4, OP_NOT = 4'h5, OP_NAND = 4'h6, OP_NOR = 4'h7,
                         OP_SHL = 4'h8, OP_SHR = 4'h9, OP_SRA = 4'hA, OP_ROL = 4'hB,
                         OP_INC = 4'hC, OP_DEC = 4'hD;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

  state_t           state_reg, state_next;
  logic             lvalid_reg;
  logic [WIDTH-1:0] la_reg, lb_reg;
  logic [3:0]       ls_reg;
  logic [WIDTH-1:0] wa_reg, wb_reg, acc_hi_reg, acc_lo_reg;
  logic             is_div_reg;
  logic [SHW-1:0]   cnt_reg;

  // DONE behaves like IDLE for accepting and dispatching, which is what
  // makes the back-to-back accept in the ack cycle work.
  logic dispatch, latched_md;
  assign in_ready   = (state_reg != BUSY);
  assign latched_md = (ls_reg[3:1] == 3'b111);
  assign dispatch   = in_ready && lvalid_reg;

  // ---------------- single-cycle datapath ----------------
  logic [WIDTH-1:0] opnd_b, sc_res, rol_res;
  logic [WIDTH:0]   add_ext, sub_ext, shl_ext, shr_ext, sra_ext;
  logic [SHW-1:0]   amt;
  logic [SHW:0]     rol_back;
  logic             sc_carry, sc_ovf, add_ovf, sub_ovf;

  always_comb begin
    opnd_b   = (ls_reg == OP_INC || ls_reg == OP_DEC) ? WIDTH'(1) : lb_reg;
    amt      = lb_reg[SHW-1:0];
    add_ext  = {1'b0, la_reg} + {1'b0, opnd_b};
    sub_ext  = {1'b0, la_reg} - {1'b0, opnd_b};
    // Extra guard bit catches the last bit shifted out (0 when amt == 0).
    shl_ext  = {1'b0, la_reg} << amt;
    shr_ext  = {la_reg, 1'b0} >> amt;
    sra_ext  = $signed({la_reg, 1'b0}) >>> amt;
    rol_back = (SHW + 1)'(WIDTH) - {1'b0, amt};
    rol_res  = (la_reg << amt) | (la_reg >> rol_back);
    add_ovf  = (la_reg[WIDTH-1] == opnd_b[WIDTH-1]) && (add_ext[WIDTH-1] != la_reg[WIDTH-1]);
    sub_ovf  = (la_reg[WIDTH-1] != opnd_b[WIDTH-1]) && (sub_ext[WIDTH-1] != la_reg[WIDTH-1]);

    sc_res   = '0;
    sc_carry = 1'b0;
    sc_ovf   = 1'b0;
    case (ls_reg)
      OP_ADD, OP_INC: begin sc_res = add_ext[WIDTH-1:0]; sc_carry = add_ext[WIDTH]; sc_ovf = add_ovf; end
      OP_SUB, OP_DEC: begin sc_res = sub_ext[WIDTH-1:0]; sc_carry = sub_ext[WIDTH]; sc_ovf = sub_ovf; end
      OP_AND:  sc_res = la_reg & lb_reg;
      OP_OR:   sc_res = la_reg | lb_reg;
      OP_XOR:  sc_res = la_reg ^ lb_reg;
      OP_NOT:  sc_res = ~la_reg;
      OP_NAND: sc_res = ~(la_reg & lb_reg);
      OP_NOR:  sc_res = ~(la_reg | lb_reg);
      OP_SHL:  begin sc_res = shl_ext[WIDTH-1:0]; sc_carry = shl_ext[WIDTH]; end
      OP_SHR:  begin sc_res = shr_ext[WIDTH:1];   sc_carry = shr_ext[0]; end
      OP_SRA:  begin sc_res = sra_ext[WIDTH:1];   sc_carry = sra_ext[0]; end
      OP_ROL:  begin sc_res = rol_res; sc_carry = (amt != '0) && rol_res[0]; end
      default: ;
    endcase
`ifdef ALU_SAT_EN
    // Arithmetic overflow always takes the sign of a toward the clamp.
    if (sc_ovf)
      sc_res = la_reg[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}} : {1'b0, {(WIDTH-1){1'b1}}};
`endif
  end

  // ---------------- bit-serial MUL / DIV step ----------------
  // MUL: {acc_hi, acc_lo} starts as {0, b}; add a on lsb, shift right.
  // DIV: acc_lo holds the dividend/quotient, acc_hi the partial remainder.
  logic [WIDTH:0]   mul_sum, div_r2;
  logic [WIDTH-1:0] div_diff, step_hi, step_lo;
  logic             div_ge;

  always_comb begin
    mul_sum  = {1'b0, acc_hi_reg} + (acc_lo_reg[0] ? {1'b0, wa_reg} : '0);
    div_r2   = {acc_hi_reg, acc_lo_reg[WIDTH-1]};
    div_ge   = div_r2 >= {1'b0, wb_reg};
    div_diff = div_r2[WIDTH-1:0] - wb_reg;
    if (is_div_reg) begin
      step_hi = div_ge ? div_diff : div_r2[WIDTH-1:0];
      step_lo = {acc_lo_reg[WIDTH-2:0], div_ge};
    end else begin
      step_hi = mul_sum[WIDTH:1];
      step_lo = {mul_sum[0], acc_lo_reg[WIDTH-1:1]};
    end
  end

  // ---------------- FSM ----------------
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, DONE: state_next = (lvalid_reg && latched_md) ? BUSY : IDLE;
      BUSY:       state_next = (cnt_reg == '0) ? DONE : BUSY;
      default:    state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg  <= IDLE;
      lvalid_reg <= 1'b0;
      la_reg     <= '0;
      lb_reg     <= '0;
      ls_reg     <= '0;
      wa_reg     <= '0;
      wb_reg     <= '0;
      acc_hi_reg <= '0;
      acc_lo_reg <= '0;
      is_div_reg <= 1'b0;
      cnt_reg    <= '0;
      res        <= '0;
      res_hi     <= '0;
      carry      <= 1'b0;
      zero       <= 1'b0;
      ovf        <= 1'b0;
      dz         <= 1'b0;
      ack        <= 1'b0;
    end else begin
      state_reg <= state_next;
      ack       <= 1'b0;

      // A new accept replaces the op being dispatched on the same edge.
      if (in_valid && in_ready) begin
        lvalid_reg <= 1'b1;
        la_reg     <= a;
        lb_reg     <= b;
        ls_reg     <= s;
      end else if (dispatch) begin
        lvalid_reg <= 1'b0;
      end

      if (dispatch) begin
        if (latched_md) begin
          is_div_reg <= ls_reg[0];
          wa_reg     <= la_reg;
          wb_reg     <= lb_reg;
          acc_hi_reg <= '0;
          acc_lo_reg <= ls_reg[0] ? la_reg : lb_reg;
          cnt_reg    <= SHW'(WIDTH - 1);
        end else begin
          res    <= sc_res;
          res_hi <= '0;
          carry  <= sc_carry;
          ovf    <= sc_ovf;
          zero   <= (sc_res == '0);
          dz     <= 1'b0;
          ack    <= 1'b1;
        end
      end

      if (state_reg == BUSY) begin
        acc_hi_reg <= step_hi;
        acc_lo_reg <= step_lo;
        cnt_reg    <= cnt_reg - 1'b1;
        if (cnt_reg == '0) begin
          ack   <= 1'b1;
          carry <= 1'b0;
          if (is_div_reg && wb_reg == '0) begin
            res    <= '1;
            res_hi <= wa_reg;
            zero   <= 1'b0;
            ovf    <= 1'b0;
            dz     <= 1'b1;
          end else begin
            res    <= step_lo;
            res_hi <= step_hi;
            zero   <= (step_lo == '0);
            ovf    <= !is_div_reg && (step_hi != '0);
            dz     <= 1'b0;
          end
        end
      end
    end
  end

endmodule
